vga_axi_burst_rd_ctrl: RTL and testbench

VGA_AXI_BURST_RD_CTRL -- requirements
Module: vga_axi_burst_rd_ctrl

---
 rtl/vga_axi_burst_rd_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_vga_axi_burst_rd_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_axi_burst_rd_ctrl.sv
// ---------------------------------------------------------------------------
// vga_axi_burst_rd_ctrl
// Fetches one video line from a frame buffer over an AXI4 read channel as a
// sequence of INCR bursts and buffers the words in a line FIFO feeding the
// pixel pipeline. A burst is only issued once the FIFO has room for all of
// its beats, so the R channel is never back-pressured and at most one burst
// is ever in flight.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   line_req_i        one-cycle request to fetch line line_idx_i
//   line_idx_i        line number, sampled with line_req_i
//   m_ar*             AXI read address channel (master side)
//   m_r*              AXI read data channel (master side)
//   pxl_data_o        FIFO head word (combinational view of FIFO storage)
//   pxl_valid_o       FIFO not empty
//   pxl_pop_i         consume the head word
//   busy_o            line fetch in progress
//   err_o             sticky: a beat returned a non-OKAY response
//   ovr_o             sticky: line request arrived while busy
//   urun_o            sticky: pop attempted on an empty FIFO
// ---------------------------------------------------------------------------
module vga_axi_burst_rd_ctrl #(
  parameter int unsigned                  AXI_ADDR_WIDTH = 32,
  parameter int unsigned                  AXI_DATA_WIDTH = 64,
  parameter int unsigned                  BURST_LEN      = 16,
  parameter int unsigned                  LINE_WORDS     = 80,
  parameter int unsigned                  FIFO_DEPTH     = 32,
  parameter int unsigned                  LINE_CTR_WIDTH = 10,
  parameter logic [AXI_ADDR_WIDTH-1:0]    BASE_ADDR      = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      line_req_i,
  input  logic [LINE_CTR_WIDTH-1:0] line_idx_i,
  output logic [AXI_ADDR_WIDTH-1:0] m_araddr_o,
  output logic [7:0]                m_arlen_o,
  output logic [2:0]                m_arsize_o,
  output logic [1:0]                m_arburst_o,
  output logic [2:0]                m_arprot_o,
  output logic                      m_arvalid_o,
  input  logic                      m_arready_i,
  input  logic [AXI_DATA_WIDTH-1:0] m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  input  logic                      m_rlast_i,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o,
  output logic [AXI_DATA_WIDTH-1:0] pxl_data_o,
  output logic                      pxl_valid_o,
  input  logic                      pxl_pop_i,
  output logic                      busy_o,
  output logic                      err_o,
  output logic                      ovr_o,
  output logic                      urun_o
);

  localparam int unsigned BYTES  = AXI_DATA_WIDTH / 8;
  localparam int unsigned SIZE   = $clog2(BYTES);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WL_W   = $clog2(LINE_WORDS + 1);
  localparam int unsigned LEN_W  = 9;
  localparam int unsigned CMP_W  = ((CNT_W > LEN_W) ? CNT_W : LEN_W) + 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] LINE_BYTES = AXI_ADDR_WIDTH'(LINE_WORDS * BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] WORD_BYTES = AXI_ADDR_WIDTH'(BYTES);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SPACE = 2'd1,
    ADDR       = 2'd2,
    DATA       = 2'd3
  } state_t;

  state_t                    state;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [WL_W-1:0]           words_left;

  logic [AXI_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          fifo_cnt;

  logic                      pop_ok_c;
  logic                      push_c;
  logic [LEN_W-1:0]          len_c;
  logic [CMP_W-1:0]          free_c;
  logic                      space_ok_c;
  logic                      last_burst_c;
  logic [CNT_W-1:0]          cnt_nxt_c;

  // Fixed AXI attributes: full-width beats, INCR bursts, privileged data access.
  assign m_arsize_o  = 3'(SIZE);
  assign m_arburst_o = 2'b01;
  assign m_arprot_o  = 3'b001;

  // Head of the FIFO is visible straight from storage.
  assign pxl_data_o  = mem[rd_ptr];

  // Pops on an empty FIFO are dropped; pushes only happen while draining a burst.
  assign pop_ok_c  = pxl_pop_i && (fifo_cnt != '0);
  assign push_c    = (state == DATA) && m_rvalid_i;
  assign cnt_nxt_c = fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_ok_c);

  // Burst length is the smaller of the burst limit and what remains of the line;
  // words_left only changes on RLAST, so len_c is stable for a whole burst.
  assign len_c = (32'(words_left) >= BURST_LEN) ? LEN_W'(BURST_LEN) : LEN_W'(words_left);
  assign last_burst_c = (words_left == WL_W'(len_c));

  // Free space counts the entry released by a pop in this same cycle.
  assign free_c     = CMP_W'(FIFO_DEPTH) - CMP_W'(fifo_cnt) + CMP_W'(pop_ok_c);
  assign space_ok_c = (free_c >= CMP_W'(len_c));

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // FIFO storage; no reset needed since pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= m_rdata_i;
    end
  end

  // Fetch FSM, FIFO bookkeeping and sticky status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      addr        <= '0;
      words_left  <= '0;
      m_araddr_o  <= '0;
      m_arlen_o   <= '0;
      m_arvalid_o <= 1'b0;
      m_rready_o  <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      ovr_o       <= 1'b0;
      urun_o      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      pxl_valid_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (line_req_i) begin
            addr       <= BASE_ADDR + AXI_ADDR_WIDTH'(line_idx_i) * LINE_BYTES;
            words_left <= WL_W'(LINE_WORDS);
            busy_o     <= 1'b1;
            state      <= WAIT_SPACE;
          end
        end

        // Hold off the address until every beat of the burst has a FIFO slot.
        WAIT_SPACE: begin
          if (space_ok_c) begin
            m_araddr_o  <= addr;
            m_arlen_o   <= 8'(len_c - LEN_W'(1));
            m_arvalid_o <= 1'b1;
            state       <= ADDR;
          end
        end

        ADDR: begin
          if (m_arready_i) begin
            m_arvalid_o <= 1'b0;
            m_rready_o  <= 1'b1;
            state       <= DATA;
          end
        end

        DATA: begin
          if (m_rvalid_i && m_rlast_i) begin
            m_rready_o <= 1'b0;
            addr       <= addr + AXI_ADDR_WIDTH'(len_c) * WORD_BYTES;
            words_left <= words_left - WL_W'(len_c);
            if (last_burst_c) begin
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              state  <= WAIT_SPACE;
            end
          end
        end

        default: state <= IDLE;
      endcase

      if (line_req_i && (state != IDLE)) begin
        ovr_o <= 1'b1;
      end
      if (pxl_pop_i && (fifo_cnt == '0)) begin
        urun_o <= 1'b1;
      end
      if (push_c && (m_rresp_i != 2'b00)) begin
        err_o <= 1'b1;
      end

      if (push_c) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop_ok_c) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      fifo_cnt    <= cnt_nxt_c;
      pxl_valid_o <= (cnt_nxt_c != '0);
    end
  end

endmodule

// File: tb/tb_vga_axi_burst_rd_ctrl.sv
`timescale 1ns/1ps
module tb_vga_axi_burst_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Main instance: default parameters (80 words/line, 64-bit words).
  logic        line_req_i;
  logic [9:0]  line_idx_i;
  logic [31:0] m_araddr_o;
  logic [7:0]  m_arlen_o;
  logic [2:0]  m_arsize_o;
  logic [1:0]  m_arburst_o;
  logic [2:0]  m_arprot_o;
  logic        m_arvalid_o;
  logic        m_arready_i;
  logic [63:0] m_rdata_i;
  logic [1:0]  m_rresp_i;
  logic        m_rlast_i;
  logic        m_rvalid_i;
  logic        m_rready_o;
  logic [63:0] pxl_data_o;
  logic        pxl_valid_o;
  logic        pxl_pop_i;
  logic        busy_o, err_o, ovr_o, urun_o;

  vga_axi_burst_rd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .line_req_i(line_req_i), .line_idx_i(line_idx_i),
    .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o), .m_arsize_o(m_arsize_o),
    .m_arburst_o(m_arburst_o), .m_arprot_o(m_arprot_o), .m_arvalid_o(m_arvalid_o),
    .m_arready_i(m_arready_i), .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i),
    .m_rlast_i(m_rlast_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .pxl_data_o(pxl_data_o), .pxl_valid_o(pxl_valid_o), .pxl_pop_i(pxl_pop_i),
    .busy_o(busy_o), .err_o(err_o), .ovr_o(ovr_o), .urun_o(urun_o)
  );

  // Second instance: 20-word line, so the last burst is a short one.
  logic        line_req2;
  logic [9:0]  line_idx2;
  logic [31:0] araddr2;
  logic [7:0]  arlen2;
  logic [2:0]  arsize2;
  logic [1:0]  arburst2;
  logic [2:0]  arprot2;
  logic        arvalid2, arready2;
  logic [63:0] rdata2;
  logic [1:0]  rresp2;
  logic        rlast2, rvalid2, rready2;
  logic [63:0] pxl_data2;
  logic        pxl_valid2, pxl_pop2;
  logic        busy2, err2, ovr2, urun2;

  vga_axi_burst_rd_ctrl #(.LINE_WORDS(20)) dut2 (
    .clk(clk), .rst_n(rst_n), .line_req_i(line_req2), .line_idx_i(line_idx2),
    .m_araddr_o(araddr2), .m_arlen_o(arlen2), .m_arsize_o(arsize2),
    .m_arburst_o(arburst2), .m_arprot_o(arprot2), .m_arvalid_o(arvalid2),
    .m_arready_i(arready2), .m_rdata_i(rdata2), .m_rresp_i(rresp2),
    .m_rlast_i(rlast2), .m_rvalid_i(rvalid2), .m_rready_o(rready2),
    .pxl_data_o(pxl_data2), .pxl_valid_o(pxl_valid2), .pxl_pop_i(pxl_pop2),
    .busy_o(busy2), .err_o(err2), .ovr_o(ovr2), .urun_o(urun2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pix(input logic [31:0] a);
    return {16'hD00D, 16'h0000, a};
  endfunction

  // Scoreboards: expected AR beats and expected pixel words.
  logic [31:0] exp_ar_addr[$];
  logic [7:0]  exp_ar_len[$];
  logic [63:0] pix_q[$];
  logic [31:0] exp2_addr[$];
  logic [7:0]  exp2_len[$];
  int          ar_cyc_log[$];

  // Slave-model state.
  logic [31:0] bq_addr[$];
  logic [7:0]  bq_len[$];
  int          beat, gb, ar_cyc, ar_hold, err_beat;
  logic        prev_ar, prev_r, pop_en;
  logic [31:0] ar_addr_s, ar_first_addr;
  logic [7:0]  ar_len_s, ar_first_len;
  logic [31:0] bq2_addr[$];
  logic [7:0]  bq2_len[$];
  int          beat2;
  logic        prev_ar2, prev_r2;
  logic [31:0] ar2_addr_s;
  logic [7:0]  ar2_len_s;

  task automatic push_line(input int idx);
    for (int k = 0; k < 80; k++) pix_q.push_back(pix(32'(idx * 640 + 8 * k)));
  endtask

  task automatic push_ar(input logic [31:0] a, input logic [7:0] l);
    exp_ar_addr.push_back(a);
    exp_ar_len.push_back(l);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // AXI slave and pixel consumer, acting on the falling edge.
  initial begin
    beat = 0; gb = 0; ar_cyc = 0; ar_hold = 0; err_beat = -1;
    prev_ar = 0; prev_r = 0; prev_ar2 = 0; prev_r2 = 0; beat2 = 0;
    m_arready_i = 0; m_rvalid_i = 0; m_rlast_i = 0; m_rresp_i = 0; m_rdata_i = '0;
    pxl_pop_i = 0; arready2 = 0; rvalid2 = 0; rlast2 = 0; rresp2 = 0; rdata2 = '0;
    pxl_pop2 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bq_addr.delete(); bq_len.delete(); bq2_addr.delete(); bq2_len.delete();
        beat = 0; beat2 = 0; gb = 0; ar_cyc = 0;
        prev_ar = 0; prev_r = 0; prev_ar2 = 0; prev_r2 = 0;
        m_arready_i = 0; m_rvalid_i = 0; m_rlast_i = 0; m_rresp_i = 0;
        arready2 = 0; rvalid2 = 0; rlast2 = 0;
        pxl_pop_i = 0; pxl_pop2 = 0;
        continue;
      end
      // Handshakes completed on the previous rising edge.
      if (prev_ar) begin
        if (exp_ar_addr.size() == 0) check("unexpected_ar", ar_addr_s, 32'hFFFF_FFFF);
        else begin
          check("araddr", ar_addr_s, exp_ar_addr.pop_front());
          check("arlen", ar_len_s, exp_ar_len.pop_front());
        end
        bq_addr.push_back(ar_addr_s);
        bq_len.push_back(ar_len_s);
        ar_cyc_log.push_back(ar_cyc);
        ar_cyc = 0;
      end
      if (prev_r) begin
        gb++;
        beat++;
        if (beat > int'(bq_len[0])) begin
          void'(bq_addr.pop_front());
          void'(bq_len.pop_front());
          beat = 0;
        end
      end
      if (prev_ar2) begin
        if (exp2_addr.size() == 0) check("unexpected_ar2", ar2_addr_s, 32'hFFFF_FFFF);
        else begin
          check("araddr2", ar2_addr_s, exp2_addr.pop_front());
          check("arlen2", ar2_len_s, exp2_len.pop_front());
        end
        bq2_addr.push_back(ar2_addr_s);
        bq2_len.push_back(ar2_len_s);
      end
      if (prev_r2) begin
        beat2++;
        if (beat2 > int'(bq2_len[0])) begin
          void'(bq2_addr.pop_front());
          void'(bq2_len.pop_front());
          beat2 = 0;
        end
      end
      // Pixel consumer: the head word is compared when it is about to be popped.
      pxl_pop_i = pop_en;
      if (pop_en && pxl_valid_o) begin
        if (pix_q.size() == 0) check("extra_pixel", pxl_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        else check("pixel", pxl_data_o, pix_q.pop_front());
      end
      pxl_pop2 = 1'b1;
      // Address channel, optionally stalled for ar_hold cycles.
      if (m_arvalid_o) begin
        ar_cyc++;
        if (ar_cyc == 1) begin
          ar_first_addr = m_araddr_o;
          ar_first_len  = m_arlen_o;
        end else begin
          check("araddr_stable", m_araddr_o, ar_first_addr);
          check("arlen_stable", m_arlen_o, ar_first_len);
        end
        if (ar_hold > 0) begin
          m_arready_i = 0;
          ar_hold--;
        end else m_arready_i = 1;
      end else m_arready_i = 0;
      arready2 = 1'b1;
      // Read data: word content is the beat's byte address.
      if (bq_addr.size() != 0) begin
        m_rvalid_i = 1;
        m_rdata_i  = pix(bq_addr[0] + 32'(8 * beat));
        m_rlast_i  = (beat == int'(bq_len[0]));
        m_rresp_i  = (gb == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_rvalid_i = 0; m_rlast_i = 0; m_rresp_i = 0;
      end
      if (bq2_addr.size() != 0) begin
        rvalid2 = 1;
        rdata2  = pix(bq2_addr[0] + 32'(8 * beat2));
        rlast2  = (beat2 == int'(bq2_len[0]));
      end else begin
        rvalid2 = 0; rlast2 = 0;
      end
      rresp2 = 2'b00;
      prev_ar   = m_arvalid_o && m_arready_i;
      ar_addr_s = m_araddr_o;
      ar_len_s  = m_arlen_o;
      prev_r    = m_rvalid_i && m_rready_o;
      prev_ar2   = arvalid2 && arready2;
      ar2_addr_s = araddr2;
      ar2_len_s  = arlen2;
      prev_r2    = rvalid2 && rready2;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    rst_n = 0; line_req_i = 0; line_idx_i = '0; line_req2 = 0; line_idx2 = '0; pop_en = 0;
    step(3);
    // Reset values.
    check("rst_arvalid", m_arvalid_o, 0);
    check("rst_rready", m_rready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_pxl_valid", pxl_valid_o, 0);
    check("rst_flags", {err_o, ovr_o, urun_o}, 0);
    check("rst_araddr", m_araddr_o, 0);
    check("rst_arlen", m_arlen_o, 0);
    check("arsize", m_arsize_o, 3);
    check("arburst", m_arburst_o, 1);
    check("arprot", m_arprot_o, 1);
    rst_n = 1;
    step(2);

    // Line 2, no pops: two bursts then a stall with the FIFO full.
    push_ar(32'h500, 8'd15);
    push_ar(32'h580, 8'd15);
    push_line(2);
    line_req_i = 1; line_idx_i = 10'd2;
    step(1);
    line_req_i = 0;
    check("busy_after_req", busy_o, 1);
    step(70);
    check("stall_ar_left", exp_ar_addr.size(), 0);
    check("stall_busy", busy_o, 1);
    check("stall_arvalid", m_arvalid_o, 0);
    check("stall_fifo_cnt", 32'(dut.fifo_cnt), 32);
    check("stall_state", 32'(dut.state), 1);
    check("stall_pxl_valid", pxl_valid_o, 1);
    // Request while busy is ignored and flagged.
    line_req_i = 1; line_idx_i = 10'd5;
    step(1);
    line_req_i = 0;
    step(1);
    check("ovr_set", ovr_o, 1);
    check("urun_clear", urun_o, 0);

    // Start consuming: remaining three bursts and all 80 words in order.
    push_ar(32'h600, 8'd15);
    push_ar(32'h680, 8'd15);
    push_ar(32'h700, 8'd15);
    pop_en = 1;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      step(1);
      if (pix_q.size() == 0 && !busy_o) begin ok = 1; break; end
    end
    check("lineA_done", ok, 1);
    step(3);
    check("lineA_ar_left", exp_ar_addr.size(), 0);
    check("lineA_busy", busy_o, 0);
    check("lineA_empty", pxl_valid_o, 0);
    check("lineA_urun", urun_o, 1);
    check("lineA_err", err_o, 0);
    check("lineA_ovr", ovr_o, 1);

    // Line 1 with a 7-cycle ARREADY stall and one SLVERR beat.
    rst_n = 0;
    step(2);
    exp_ar_addr.delete(); exp_ar_len.delete(); pix_q.delete(); ar_cyc_log.delete();
    check("rst2_flags", {err_o, ovr_o, urun_o}, 0);
    rst_n = 1;
    step(1);
    ar_hold = 7; err_beat = 3;
    for (int b = 0; b < 5; b++) push_ar(32'(32'h280 + 32'h80 * b), 8'd15);
    push_line(1);
    pop_en = 1;
    line_req_i = 1; line_idx_i = 10'd1;
    step(1);
    line_req_i = 0;
    ok = 0;
    for (int i = 0; i < 800; i++) begin
      step(1);
      if (pix_q.size() == 0 && !busy_o) begin ok = 1; break; end
    end
    check("lineB_done", ok, 1);
    check("lineB_ar_left", exp_ar_addr.size(), 0);
    check("lineB_ar_cycles", (ar_cyc_log.size() > 0) ? ar_cyc_log[0] : 0, 8);
    check("lineB_err", err_o, 1);
    check("lineB_ovr", ovr_o, 0);
    err_beat = -1;
    step(2);

    // Line 3, reset asserted in the middle of the first data burst.
    pop_en = 0;
    push_ar(32'h780, 8'd15);
    line_req_i = 1; line_idx_i = 10'd3;
    step(1);
    line_req_i = 1;
    step(1);
    line_req_i = 0;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (m_rready_o) begin ok = 1; break; end
    end
    check("lineC_in_data", ok, 1);
    step(5);
    check("lineC_pre_valid", pxl_valid_o, 1);
    check("lineC_pre_flags", {err_o, ovr_o, urun_o}, 3'b111);
    check("lineC_pre_rready", m_rready_o, 1);
    rst_n = 0;
    #1;
    check("midrst_arvalid", m_arvalid_o, 0);
    check("midrst_rready", m_rready_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_pxl_valid", pxl_valid_o, 0);
    check("midrst_flags", {err_o, ovr_o, urun_o}, 0);
    check("midrst_araddr", m_araddr_o, 0);
    check("midrst_arlen", m_arlen_o, 0);
    check("midrst_fifo_cnt", 32'(dut.fifo_cnt), 0);
    step(2);
    exp_ar_addr.delete(); exp_ar_len.delete(); pix_q.delete();
    rst_n = 1;
    step(2);

    // 20-word line: a full burst followed by a 4-beat burst.
    exp2_addr.push_back(32'hA0);  exp2_len.push_back(8'd15);
    exp2_addr.push_back(32'h120); exp2_len.push_back(8'd3);
    line_req2 = 1; line_idx2 = 10'd1;
    step(1);
    line_req2 = 0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (!busy2) begin ok = 1; break; end
    end
    check("lineD_done", ok, 1);
    check("lineD_ar_left", exp2_addr.size(), 0);
    check("lineD_idle_main", busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
